// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path: opcodes (common with the
// ALU), sequencer FSM states and instruction field positions.
package proc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_WRITE,
        ST_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/reg_file.sv
// General-purpose register file: registered operand pair, combinational debug
// port, one synchronous write port, asynchronous active-low clear.
module reg_file #(
    parameter int NREGS = 16,
    parameter int DW    = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            ra_data <= '0;
            rb_data <= '0;
        end else begin
            if (we) begin
                mem[wa] <= wd;
            end
            // Operands are captured once and held, so a later write to rd cannot disturb them
            if (rd_en) begin
                ra_data <= mem[ra_addr];
                rb_data <= mem[rb_addr];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer in front of the 8-bit ALU: fetch handshake,
// operand read, two-cycle ALU execution, write-back and flag update.
module alu_sequencer
    import proc_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [3:0]               alu_op,
    input  logic [DW-1:0]            alu_result,
    input  logic                     alu_carry,
    input  logic                     alu_sinal,
    output logic                     carry_flag,
    output logic                     sign_flag,
    output logic                     zero_flag,
    output logic                     busy,
    output logic                     halted,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    localparam int AW = $clog2(NREGS);

    state_t        state_q, state_d;
    logic [15:0]   ir;
    logic [3:0]    opc;
    logic [DW-1:0] wdata;
    logic          we;

    assign opc   = ir[OPC_HI:OPC_LO];
    assign wdata = (opc == OP_LDI) ? DW'(ir[IMM_HI:IMM_LO]) : alu_result;
    assign we    = (state_q == ST_WRITE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ir         <= '0;
            carry_flag <= 1'b0;
            sign_flag  <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && instr_valid) begin
                ir <= instr;
            end
            // Only ALU ops and LDI reach WRITE, so zero always updates there
            if (state_q == ST_WRITE) begin
                if (opc == OP_ADD) carry_flag <= alu_carry;
                if (opc == OP_SUB) sign_flag  <= alu_sinal;
                zero_flag <= (wdata == '0);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_alu_op(opc))      state_d = ST_EXEC1;
                else if (opc == OP_LDI)  state_d = ST_WRITE;
                else if (opc == OP_HALT) state_d = ST_HALT;
                else                     state_d = ST_IDLE;
            end
            ST_EXEC1:  state_d = ST_EXEC2;
            ST_EXEC2:  state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign alu_op      = (state_q == ST_EXEC1 || state_q == ST_EXEC2) ? opc : 4'h0;

    reg_file #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (state_q == ST_DECODE),
        .ra_addr  (ir[RS_HI:RS_LO]),
        .rb_addr  (ir[RT_HI:RT_LO]),
        .ra_data  (alu_a),
        .rb_data  (alu_b),
        .we       (we),
        .wa       (ir[RD_HI:RD_LO]),
        .wd       (wdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: clocked stand-in ALU, instruction-level reference
// model with per-cycle comparison, directed scenarios and random programs.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_q;
    logic        alu_cq, alu_sq;
    logic        carry_flag, sign_flag, zero_flag, busy, halted;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int total = 0;
    int bad   = 0;
    bit cmp_en  = 0;
    bit dbg_rand = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.NREGS(16), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_q),
        .alu_carry   (alu_cq),
        .alu_sinal   (alu_sq),
        .carry_flag  (carry_flag),
        .sign_flag   (sign_flag),
        .zero_flag   (zero_flag),
        .busy        (busy),
        .halted      (halted),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return ~b;
            4'h6:    return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic add_carry(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8];
    endfunction

    function automatic bit is_alu(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h6);
    endfunction

    function automatic int latency(input logic [3:0] op);
        if (is_alu(op))   return 4;
        if (op == 4'h7)   return 2;
        return 1;
    endfunction

    // Stand-in for the external ALU: its outputs are registered
    always @(posedge clk) begin
        alu_q  <= alu_fn(alu_op, alu_a, alu_b);
        alu_cq <= add_carry(alu_a, alu_b);
        alu_sq <= (alu_a < alu_b);
    end

    // Instruction-level model: an accepted instruction takes effect after its latency
    int         m_left;
    bit         m_halt;
    logic [7:0] m_reg [16];
    logic       m_c, m_s, m_z;
    logic [3:0] m_op, m_rd;
    logic [7:0] m_a, m_b, m_imm;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0;
            m_halt <= 1'b0;
            m_c <= 1'b0; m_s <= 1'b0; m_z <= 1'b0;
            m_op <= 4'h0; m_rd <= 4'h0; m_a <= 8'h00; m_b <= 8'h00; m_imm <= 8'h00;
            for (int i = 0; i < 16; i++) m_reg[i] <= 8'h00;
        end else if (m_left == 0) begin
            if (!m_halt && instr_valid) begin
                m_op   <= instr[15:12];
                m_rd   <= instr[11:8];
                m_a    <= m_reg[instr[7:4]];
                m_b    <= m_reg[instr[3:0]];
                m_imm  <= instr[7:0];
                m_left <= latency(instr[15:12]);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                if (is_alu(m_op)) begin
                    m_reg[m_rd] <= alu_fn(m_op, m_a, m_b);
                    m_z <= (alu_fn(m_op, m_a, m_b) == 8'h00);
                    if (m_op == 4'h1) m_c <= add_carry(m_a, m_b);
                    if (m_op == 4'h2) m_s <= (m_a < m_b);
                end else if (m_op == 4'h7) begin
                    m_reg[m_rd] <= m_imm;
                    m_z <= (m_imm == 8'h00);
                end else if (m_op == 4'hF) begin
                    m_halt <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison, sampled mid-cycle away from both clock edges
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (cmp_en) begin
                chk("ready",  {15'd0, instr_ready}, {15'd0, (m_left == 0) && !m_halt});
                chk("busy",   {15'd0, busy},        {15'd0, m_left > 0});
                chk("halted", {15'd0, halted},      {15'd0, m_halt});
                chk("flags",  {13'd0, carry_flag, sign_flag, zero_flag}, {13'd0, m_c, m_s, m_z});
                chk("dbg",    {8'd0, dbg_data},     {8'd0, m_reg[dbg_addr]});
                if ((m_left == 3 || m_left == 2) && is_alu(m_op)) begin
                    chk("alu_op", {12'd0, alu_op}, {12'd0, m_op});
                    chk("alu_ab", {alu_a, alu_b},  {m_a, m_b});
                end else begin
                    chk("alu_op_idle", {12'd0, alu_op}, 16'h0000);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (dbg_rand) dbg_addr = 4'($urandom_range(0, 15));
        end
    end

    // Called at a negedge; returns at the negedge of the first cycle after transfer
    task automatic send(input logic [15:0] w, input bit junk);
        int n = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("send_timeout", 16'd1, 16'd0);
        @(negedge clk);
        if (junk) instr = {4'($urandom_range(1, 7)), 12'($urandom)};
        else instr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        instr_valid = 1'b0;
        if (n >= 40) chk("idle_timeout", 16'd1, 16'd0);
    endtask

    task automatic exec(input logic [15:0] w, output int n);
        send(w, 1'b0);
        wait_idle(n);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    initial begin
        int n;
        logic [7:0] d;
        rst = 1'b1;
        instr = 16'h0000;
        instr_valid = 1'b0;
        dbg_addr = 4'h0;
        #1 rst = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_busy_halt", {14'd0, busy, halted}, 16'd0);
        chk("rst_flags", {13'd0, carry_flag, sign_flag, zero_flag}, 16'd0);
        chk("rst_aluop", {12'd0, alu_op}, 16'd0);
        chk("rst_dbg", {8'd0, dbg_data}, 16'd0);
        rst = 1'b1;
        @(negedge clk);

        // Raise carry/zero, then reset in the middle of ADD R1
        exec(16'h73FF, n);
        exec(16'h7401, n);
        exec(16'h1534, n);
        chk("pre_rst_flags", {13'd0, carry_flag, sign_flag, zero_flag}, 16'h0005);
        exec(16'h7105, n);
        chk("ldi_latency", 16'(n), 16'd2);
        send(16'h1112, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        peek(4'h1, d);
        chk("abort_r1", {8'd0, d}, 16'h0000);
        chk("abort_ready", {15'd0, instr_ready}, 16'd1);
        chk("abort_flags", {13'd0, carry_flag, sign_flag, zero_flag}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        exec(16'h717F, n);
        exec(16'h7201, n);
        exec(16'h1312, n);
        chk("add_latency", 16'(n), 16'd4);
        peek(4'h3, d);
        chk("r3_7f_plus_1", {8'd0, d}, 16'h0080);
        chk("add_flags", {13'd0, carry_flag, sign_flag, zero_flag}, 16'h0000);

        exec(16'h71FF, n);
        exec(16'h7201, n);
        exec(16'h1112, n);
        peek(4'h1, d);
        chk("r1_wrap", {8'd0, d}, 16'h0000);
        chk("wrap_flags", {13'd0, carry_flag, sign_flag, zero_flag}, 16'h0005);
        exec(16'h3412, n);
        chk("and_keeps_carry", {15'd0, carry_flag}, 16'd1);
        exec(16'h0000, n);
        chk("nop_latency", 16'(n), 16'd1);

        exec(16'h7503, n);
        exec(16'h7609, n);
        exec(16'h2756, n);
        peek(4'h7, d);
        chk("r7_3_minus_9", {8'd0, d}, 16'h00FA);
        chk("sub_sign", {15'd0, sign_flag}, 16'd1);
        exec(16'h6856, n);
        peek(4'h8, d);
        chk("r8_xor", {8'd0, d}, 16'h000A);
        chk("xor_keeps_sign", {13'd0, carry_flag, sign_flag, zero_flag}, 16'h0006);

        // A different instruction held valid while busy must be ignored
        send(16'h1912, 1'b0);
        instr = 16'h7AFF;
        instr_valid = 1'b1;
        wait_idle(n);
        chk("busy_ignore_lat", 16'(n), 16'd4);
        peek(4'h9, d);
        chk("r9_from_ir", {8'd0, d}, 16'h0001);
        peek(4'hA, d);
        chk("r10_untouched", {8'd0, d}, 16'h0000);

        // Random programs, with junk presented while busy
        dbg_rand = 1'b1;
        for (int k = 0; k < 150; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(8, 14));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send({op, 12'($urandom)}, 1'($urandom_range(0, 1)));
            wait_idle(n);
            chk("rand_latency", 16'(n), 16'(latency(op)));
        end
        dbg_rand = 1'b0;

        exec(16'h7C5A, n);
        send(16'hF000, 1'b0);
        @(negedge clk);
        chk("halted", {14'd0, halted, instr_ready}, 16'h0002);
        instr = 16'h1CCC;
        instr_valid = 1'b1;
        repeat (6) @(negedge clk);
        peek(4'hC, d);
        chk("halt_no_write", {8'd0, d}, 16'h005A);
        chk("halt_stays", {13'd0, halted, instr_ready, busy}, 16'h0004);
        instr_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("halt_rst", {14'd0, halted, instr_ready}, 16'h0001);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control stage sitting directly upstream of the 8-bit ALU in the 16-bit processor. Accepts one 16-bit instruction per handshake, reads operands from an internal 16×8 register file, and drives the ALU `a`/`b`/`op` inputs. It then captures the ALU result and flags and writes the result back. The opcode map matches the ALU op codes, so `op` is forwarded unchanged for ALU instructions.

## Interface
Parameters:
- `NREGS`, 16: register-file depth, fixed by the 4-bit register fields.
- `DW`, 8: datapath width, must equal ALU width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `instr`  in  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt; for LDI, [7:0] is the immediate.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  high only in IDLE; transfer occurs when valid & ready.
- `alu_a`  out  8  operand A = R[rs].
- `alu_b`  out  8  operand B = R[rt].
- `alu_op`  out  4  ALU opcode, driven only in EXEC1/EXEC2, else 0.
- `alu_result`  in  8  ALU `out_ula`.
- `alu_carry`  in  1  ALU carry.
- `alu_sinal`  in  1  ALU subtract sign.
- `carry_flag`  out  1  last ADD carry.
- `sign_flag`  out  1  last SUB sign.
- `zero_flag`  out  1  last ALU/LDI result == 0.
- `busy`  out  1  state is not IDLE and not HALT.
- `halted`  out  1  HALT executed.
- `dbg_addr`  in  4  debug read address.
- `dbg_data`  out  8  combinational R[dbg_addr].

## Operation
- Opcodes:
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT (uses rt only), 6 XOR.
  - 7 LDI: R[rd] <= instr[7:0].
  - F HALT.
  - 0 and 8–E are NOPs.
- The instruction is latched into `ir` on transfer.
- States:
  - IDLE: on transfer, go to DECODE.
  - DECODE: latch R[rs] and R[rt] into the operand registers. ALU op goes to EXEC1, LDI to WRITE, HALT to HALT, NOP to IDLE.
  - EXEC1 → EXEC2: `alu_op` = `ir[15:12]` and operands are held stable for both cycles, allowing for the ALU's clocked subtract unit.
  - WRITE: at the WRITE clock edge, R[rd] <= `alu_result` (or the immediate for LDI). Flags update at the same edge, then go to IDLE.
  - HALT: terminal; only reset exits.
- Flag rules:
  - `carry_flag` updates on ADD only.
  - `sign_flag` updates on SUB only.
  - `zero_flag` updates on every ALU op and on LDI.
  - All other flags hold.
- rd may equal rs or rt: operands were latched in DECODE, so the write does not disturb them.
- All registers, including R0, are general purpose and writable.

## Timing
- Reset values: state IDLE, `instr_ready` = 1, `alu_a`/`alu_b`/`alu_op` = 0, all flags 0, `busy` = 0, `halted` = 0, all 16 registers = 0, `dbg_data` = 0.
- ALU op: transfer at edge T0; DECODE in cycle 1, EXEC1 in cycle 2, EXEC2 in cycle 3, WRITE in cycle 4. R[rd] is visible on `dbg_data` after the edge ending cycle 4, and `instr_ready` reasserts in cycle 5. Throughput is 1 instruction per 5 cycles.
- LDI: 3 cycles (DECODE, WRITE, then ready). NOP: 2 cycles.
- `alu_result` is sampled only at the WRITE edge.
- `instr` and `instr_valid` are ignored outside IDLE.
- `dbg_addr` == rd during WRITE returns the old value until the write edge.
- Reset asserted mid-instruction aborts it immediately. No write occurs and all state returns to reset values asynchronously.
- `halted` rises at the edge entering HALT. `busy` = 0 and `instr_ready` = 0 while halted.

## Structure
- Shared package `proc_pkg`:
  - opcode constants (ADD = 4'h1 … XOR = 4'h6, LDI = 4'h7, HALT = 4'hF), shared with the ALU.
  - the FSM state enum.
  - instruction field bit positions.
- One sub-module `reg_file`: 16×8, two registered-operand read ports, one combinational debug read port, one synchronous write port, async active-low clear.

## Test plan
- Reset mid-EXEC1 of ADD R1 (R1 = 0x05): R1 stays 0x05's reset value 0, state IDLE, `instr_ready` = 1, all flags 0.
- LDI R1, 0x7F; LDI R2, 0x01; ADD R3 = R1 + R2 (instr 0x1312): R3 = 0x80, `carry_flag` = 0, `zero_flag` = 0. `instr_ready` low for exactly 4 cycles after the ADD transfer.
- LDI R1, 0xFF; LDI R2, 0x01; ADD R1 = R1 + R2: R1 = 0x00, `carry_flag` = 1, `zero_flag` = 1. The following AND leaves `carry_flag` = 1.
- SUB with the model ALU returning `sinal` = 1: `sign_flag` = 1. A subsequent XOR leaves it at 1.
- `instr_valid` held high with a different instruction during EXEC2: not accepted, and `ir` is unchanged.
- HALT (0xF000) then valid ADD: `halted` = 1, `instr_ready` = 0, no register changes until `rst` is pulsed low.
